// File: rtl/sram_test_sequencer.sv
// Async SRAM test sequencer: writes a pattern to every address, reads it back and strobes each word to a checker.
// Optional SRAM_TEST_LFSR_PATTERN_EN selects a 16-bit LFSR pattern instead of address + pass count.
module sram_test_sequencer #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 loop,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_data_out,
  output logic                 sram_data_oe,
  input  logic [DATA_BITS-1:0] sram_data_in,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n,
  output logic                 check_enable,
  output logic [DATA_BITS-1:0] read_data,
  output logic [DATA_BITS-1:0] expected_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pass_count
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_SAMPLE, END
  } state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic                 last_addr;
  logic [DATA_BITS-1:0] pattern;

  assign last_addr = &sram_addr;

`ifdef SRAM_TEST_LFSR_PATTERN_EN
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  if (DATA_BITS != 16) begin : g_lfsr_width_check
    $error("SRAM_TEST_LFSR_PATTERN_EN requires DATA_BITS == 16");
  end

  logic [15:0] lfsr;

  function automatic logic [15:0] lfsr_seed(input logic [15:0] pc);
    logic [15:0] s;
    s = 16'hACE1 ^ pc;
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Right-shifting form; mask bit 15-i selects register bit i as a feedback tap.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (LFSR_MASK[15-i]) fb = fb ^ v[i];
    end
    return {fb, v[15:1]};
  endfunction

  always_ff @(posedge clk) begin
    case (state)
      IDLE:     if (start) lfsr <= lfsr_seed(pass_count);
      W_HOLD:   lfsr <= last_addr ? lfsr_seed(pass_count) : lfsr_step(lfsr);
      R_SAMPLE: if (!last_addr) lfsr <= lfsr_step(lfsr);
      END:      lfsr <= lfsr_seed(pass_count + 16'd1);
      default:  ;
    endcase
  end

  assign pattern = DATA_BITS'(lfsr);
`else
  function automatic logic [DATA_BITS-1:0] addr_pattern(input logic [ADDR_BITS-1:0] a,
                                                         input logic [15:0]          pc);
    return DATA_BITS'(a) + DATA_BITS'(pc);
  endfunction

  assign pattern = addr_pattern(sram_addr, pass_count);
`endif

  assign sram_data_out = sram_data_oe ? pattern : '0;

  always_comb begin
    state_next = state;
    addr_next  = sram_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = W_SETUP;
          addr_next  = '0;
        end
      end
      W_SETUP: state_next = W_PULSE;
      W_PULSE: state_next = W_HOLD;
      W_HOLD: begin
        addr_next  = sram_addr + ADDR_BITS'(1);
        state_next = last_addr ? R_SETUP : W_SETUP;
      end
      R_SETUP: state_next = R_WAIT;
      R_WAIT:  state_next = R_SAMPLE;
      R_SAMPLE: begin
        addr_next  = sram_addr + ADDR_BITS'(1);
        state_next = last_addr ? END : R_SETUP;
      end
      END: begin
        addr_next  = '0;
        state_next = loop ? W_SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they are glitch-free at the pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      sram_addr     <= '0;
      sram_data_oe  <= 1'b0;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_ce_n     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      check_enable  <= 1'b0;
      read_data     <= '0;
      expected_data <= '0;
      pass_count    <= '0;
    end else begin
      state        <= state_next;
      sram_addr    <= addr_next;
      sram_data_oe <= (state_next == W_SETUP) || (state_next == W_PULSE) || (state_next == W_HOLD);
      sram_we_n    <= (state_next != W_PULSE);
      sram_oe_n    <= !((state_next == R_SETUP) || (state_next == R_WAIT) || (state_next == R_SAMPLE));
      busy         <= (state_next != IDLE);
      sram_ce_n    <= (state_next == IDLE);
      check_enable <= (state == R_SAMPLE);
      if (state == R_SAMPLE) begin
        read_data     <= sram_data_in;
        expected_data <= pattern;
      end
      if (state == END) pass_count <= pass_count + 16'd1;
      if (state == IDLE && start) done <= 1'b0;
      else if (state == END && !loop) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench for sram_test_sequencer with a small behavioural SRAM (optional stuck-at bit on address 5).
`timescale 1ns/1ps
module tb_sram_test_sequencer;

  localparam int AB = 3;
  localparam int DB = 16;
  localparam int N  = 1 << AB;

  logic          clk = 1'b0;
  logic          reset_n, start, loop;
  logic [AB-1:0] sram_addr;
  logic [DB-1:0] sram_data_out, sram_data_in, read_data, expected_data;
  logic          sram_data_oe, sram_we_n, sram_oe_n, sram_ce_n;
  logic          check_enable, busy, done;
  logic [15:0]   pass_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit stuck_en = 1'b0;
  bit mon_en   = 1'b0;

  logic [DB-1:0] mem [0:N-1];

  sram_test_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .loop(loop),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out), .sram_data_oe(sram_data_oe),
    .sram_data_in(sram_data_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .check_enable(check_enable), .read_data(read_data),
    .expected_data(expected_data), .busy(busy), .done(done), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce_n === 1'b0 && sram_we_n === 1'b0 && sram_data_oe === 1'b1)
      mem[sram_addr] <= sram_data_out;
  end

  always_comb begin
    sram_data_in = 16'hDEAD;
    if (sram_oe_n === 1'b0 && sram_ce_n === 1'b0) begin
      sram_data_in = mem[sram_addr];
      if (stuck_en && sram_addr == 3'd5) sram_data_in[4] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ((sram_we_n === 1'b0 && sram_oe_n === 1'b0) ||
          (sram_data_oe === 1'b1 && sram_oe_n === 1'b0) ||
          (sram_ce_n !== !busy)) begin
        n_fail++;
        $display("FAIL bus_protocol t=%0t we_n=%b oe_n=%b data_oe=%b ce_n=%b busy=%b; required no we_n/oe_n overlap, no data_oe with oe_n low, ce_n=!busy",
                 $time, sram_we_n, sram_oe_n, sram_data_oe, sram_ce_n, busy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_pattern(input int a, input int p);
`ifdef SRAM_TEST_LFSR_PATTERN_EN
    logic [15:0] l;
    l = 16'hACE1 ^ 16'(p);
    if (l == 16'h0000) l = 16'h0001;
    for (int i = 0; i < a; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
`else
    return 16'(a + p);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    loop     = 1'b0;
    stuck_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the first W_SETUP cycle of a pass; leaves one cycle after END.
  task automatic verify_pass(input int p, input bit next_loop, input bit hold_start, input string tag);
    int          a;
    bit          pulse;
    logic [15:0] exp_rd;
    n_checks++;
    if (busy !== 1'b1 || sram_addr !== 3'd0 || sram_data_oe !== 1'b1 || pass_count !== 16'(p)) begin
      n_fail++;
      $display("FAIL %s_pass%0d_entry busy=%b addr=%0d data_oe=%b pass_count=%0d required busy=1 addr=0 data_oe=1 pass_count=%0d",
               tag, p, busy, sram_addr, sram_data_oe, pass_count, p);
    end
    for (int c = 0; c <= 6*N; c++) begin
      start = (c < 6*N) ? hold_start : 1'b0;
      if (c == 6*N) loop = next_loop;
      if (c < 3*N && c % 3 == 1) begin
        a = c / 3;
        n_checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== a[AB-1:0] || sram_data_out !== exp_pattern(a, p)) begin
          n_fail++;
          $display("FAIL %s_pass%0d_write c=%0d we_n=%b addr=%0d data=%h required we_n=0 addr=%0d data=%h",
                   tag, p, c, sram_we_n, sram_addr, sram_data_out, a, exp_pattern(a, p));
        end
      end
      if (c >= 3*N) begin
        pulse = (c >= 3*N + 3) && ((c - 3*N) % 3 == 0);
        n_checks++;
        if (check_enable !== pulse) begin
          n_fail++;
          $display("FAIL %s_pass%0d_strobe c=%0d check_enable=%b required %b", tag, p, c, check_enable, pulse);
        end
        if (pulse) begin
          a = (c - 3*N) / 3 - 1;
          exp_rd = exp_pattern(a, p);
          if (stuck_en && a == 5) exp_rd[4] = 1'b0;
          n_checks++;
          if (read_data !== exp_rd || expected_data !== exp_pattern(a, p)) begin
            n_fail++;
            $display("FAIL %s_pass%0d_read addr=%0d read_data=%h expected_data=%h required %h / %h",
                     tag, p, a, read_data, expected_data, exp_rd, exp_pattern(a, p));
          end
        end
      end
      tick();
    end
    n_checks++;
    if (next_loop) begin
      if (sram_addr !== 3'd0 || sram_data_oe !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          pass_count !== 16'(p + 1)) begin
        n_fail++;
        $display("FAIL %s_pass%0d_loop_next addr=%0d data_oe=%b busy=%b done=%b pass_count=%0d required 0 1 1 0 %0d",
                 tag, p, sram_addr, sram_data_oe, busy, done, pass_count, p + 1);
      end
    end else begin
      if (done !== 1'b1 || busy !== 1'b0 || sram_ce_n !== 1'b1 || pass_count !== 16'(p + 1)) begin
        n_fail++;
        $display("FAIL %s_pass%0d_finish done=%b busy=%b ce_n=%b pass_count=%0d required 1 0 1 %0d",
                 tag, p, done, busy, sram_ce_n, pass_count, p + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    loop    = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({sram_we_n, sram_oe_n, sram_ce_n, sram_data_oe, check_enable, busy, done} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL reset_ctrl we_n/oe_n/ce_n/data_oe/chk/busy/done=%b required 1110000",
               {sram_we_n, sram_oe_n, sram_ce_n, sram_data_oe, check_enable, busy, done});
    end
    n_checks++;
    if (sram_addr !== 3'd0 || sram_data_out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_bus addr=%0d data_out=%h required 0 0000", sram_addr, sram_data_out);
    end
    n_checks++;
    if (read_data !== 16'd0 || expected_data !== 16'd0 || pass_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data read=%h expected=%h pass_count=%0d required 0 0 0", read_data, expected_data, pass_count);
    end
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || sram_ce_n !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b ce_n=%b done=%b required 0 1 0", busy, sram_ce_n, done);
    end
  endtask

  task automatic test_single_pass();
    do_reset();
    pulse_start();
    verify_pass(0, 1'b0, 1'b0, "single");
  endtask

  task automatic test_loop();
    do_reset();
    pulse_start();
    verify_pass(0, 1'b1, 1'b0, "loop");
    verify_pass(1, 1'b1, 1'b0, "loop");
    verify_pass(2, 1'b0, 1'b0, "loop");
  endtask

  task automatic test_stuck_bit();
    do_reset();
    stuck_en = 1'b1;
    pulse_start();
    for (int p = 0; p < 16; p++) verify_pass(p, 1'b1, 1'b0, "stuck");
    verify_pass(16, 1'b0, 1'b0, "stuck");
    stuck_en = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int seen_chk, seen_busy;
    do_reset();
    pulse_start();
    for (int c = 0; c < 7; c++) tick();
    n_checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 3'd2) begin
      n_fail++;
      $display("FAIL midreset_pulse we_n=%b addr=%0d required 0 2", sram_we_n, sram_addr);
    end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (sram_we_n !== 1'b1 || busy !== 1'b0 || sram_addr !== 3'd0 || sram_ce_n !== 1'b1 ||
        sram_data_oe !== 1'b0 || check_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort we_n=%b busy=%b addr=%0d ce_n=%b data_oe=%b chk=%b required 1 0 0 1 0 0",
               sram_we_n, busy, sram_addr, sram_ce_n, sram_data_oe, check_enable);
    end
    reset_n = 1'b1;
    seen_chk  = 0;
    seen_busy = 0;
    for (int c = 0; c < 60; c++) begin
      if (check_enable !== 1'b0) seen_chk++;
      if (busy !== 1'b0) seen_busy++;
      tick();
    end
    n_checks++;
    if (seen_chk != 0 || seen_busy != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet check_enable_cycles=%0d busy_cycles=%0d required 0 0", seen_chk, seen_busy);
    end
    pulse_start();
    verify_pass(0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    do_reset();
    pulse_start();
    verify_pass(0, 1'b0, 1'b1, "busy_start");
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_idle busy=%b done=%b required 0 1", busy, done);
    end
  endtask

`ifdef SRAM_TEST_LFSR_PATTERN_EN
  task automatic test_lfsr();
    do_reset();
    pulse_start();
    for (int c = 0; c <= 3*N + 6; c++) begin
      if (c == 1 || c == 4) begin
        n_checks++;
        if (sram_data_out !== ((c == 1) ? 16'hACE1 : 16'h5670)) begin
          n_fail++;
          $display("FAIL lfsr_write c=%0d data=%h required %h", c, sram_data_out, (c == 1) ? 16'hACE1 : 16'h5670);
        end
      end
      if (c == 3*N + 3 || c == 3*N + 6) begin
        n_checks++;
        if (check_enable !== 1'b1 || expected_data !== ((c == 3*N + 3) ? 16'hACE1 : 16'h5670) ||
            read_data !== expected_data) begin
          n_fail++;
          $display("FAIL lfsr_read c=%0d chk=%b read=%h expected=%h required 1 %h", c, check_enable, read_data,
                   expected_data, (c == 3*N + 3) ? 16'hACE1 : 16'h5670);
        end
      end
      tick();
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single_pass();
    test_loop();
    test_stuck_bit();
    test_reset_mid_write();
    test_start_while_busy();
`ifdef SRAM_TEST_LFSR_PATTERN_EN
    test_lfsr();
`endif
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
